pipelined_multiplier: RTL and testbench

- Fully pipelined unsigned integer multiplier, DATA_LEN x DATA_LEN -> DATA_LEN (low half of product).
- Shift-add datapath split evenly across PIPELINE_STAGE register stages.
- Accepts new operands every clock; no handshake.
- Sits behind the host-interface AFU logic, which drives operands and samples result after a fixed cycle count.

---
 rtl/pipelined_multiplier.sv | 138 +++++++++++++
 tb/tb_pipelined_multiplier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_multiplier
//
// Fully pipelined unsigned shift-add multiplier producing the low DATA_LEN
// bits of a*b. The multiplier operand b is split into PIPELINE_STAGE slices
// of SLICE_W = ceil(DATA_LEN/PIPELINE_STAGE) bits. Each stage adds the
// partial products for its slice and registers the result. A new operand
// pair is accepted every clock, and the latency is PIPELINE_STAGE clocks.
//
// Parameters:
//   DATA_LEN        operand/result width in bits (>= 2)
//   PIPELINE_STAGE  register stages = latency in clocks (1..DATA_LEN)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; clears every stage register
//   a         in   [DATA_LEN-1:0] multiplicand, unsigned
//   b         in   [DATA_LEN-1:0] multiplier, unsigned
//   result    out  [DATA_LEN-1:0] (a*b) mod 2^DATA_LEN, last stage register
//   overflow  out  1 when the full product does not fit in DATA_LEN bits
//                  (present only when MULT_OVERFLOW_FLAG_EN is defined)
//
// Optional feature macro: MULT_OVERFLOW_FLAG_EN
//   When this macro is defined, the accumulators widen to 2*DATA_LEN bits
//   and the overflow port is added. The overflow flag comes from the upper
//   half of the last stage accumulator, so it lines up with result.
// ---------------------------------------------------------------------------
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
`ifdef MULT_OVERFLOW_FLAG_EN
    output logic                overflow,
`endif
    output logic [DATA_LEN-1:0] result
);

    localparam int SLICE_W = (DATA_LEN + PIPELINE_STAGE - 1) / PIPELINE_STAGE;
`ifdef MULT_OVERFLOW_FLAG_EN
    localparam int ACC_W = 2 * DATA_LEN;
`else
    localparam int ACC_W = DATA_LEN;
`endif

    // An illegal configuration stops elaboration.
    generate
        if ((DATA_LEN < 2) || (PIPELINE_STAGE < 1) || (PIPELINE_STAGE > DATA_LEN)) begin : g_bad_cfg
            $error("pipelined_multiplier: PIPELINE_STAGE must be 1..DATA_LEN and DATA_LEN >= 2");
        end
    endgenerate

    // Adds the partial products for the b bits owned by slice stage_idx
    // onto acc_v. Bits outside the slice contribute nothing. Because of
    // this, a narrow last slice and any slice past DATA_LEN need no extra
    // handling.
    function automatic logic [ACC_W-1:0] slice_sum(
        input logic [DATA_LEN-1:0] a_v,
        input logic [DATA_LEN-1:0] b_v,
        input logic [ACC_W-1:0]    acc_v,
        input int                  stage_idx
    );
        logic [ACC_W-1:0] sum_v;
        logic [ACC_W-1:0] a_ext_v;
        sum_v   = acc_v;
        a_ext_v = ACC_W'(a_v);
        for (int j = 0; j < DATA_LEN; j++) begin
            if ((j >= stage_idx * SLICE_W) && (j < (stage_idx + 1) * SLICE_W) && b_v[j]) begin
                sum_v = sum_v + (a_ext_v << j);
            end else begin
                sum_v = sum_v;
            end
        end
        return sum_v;
    endfunction

    // Stage registers: a carried copy of a, the b operand, and the running sum.
    logic [DATA_LEN-1:0] a_r        [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] b_r        [PIPELINE_STAGE];
    logic [ACC_W-1:0]    acc_r      [PIPELINE_STAGE];

    // Stage inputs and the combinational sum for each stage.
    logic [DATA_LEN-1:0] a_in_s     [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] b_in_s     [PIPELINE_STAGE];
    logic [ACC_W-1:0]    acc_in_s   [PIPELINE_STAGE];
    logic [ACC_W-1:0]    acc_next_s [PIPELINE_STAGE];

    // Stage input selection and per-stage partial-product addition.
    // Stage 0 takes the ports and a zero sum; the later stages take the
    // registers of the stage before them.
    always_comb begin
        for (int g = 0; g < PIPELINE_STAGE; g++) begin
            a_in_s[g]     = {DATA_LEN{1'b0}};
            b_in_s[g]     = {DATA_LEN{1'b0}};
            acc_in_s[g]   = {ACC_W{1'b0}};
            acc_next_s[g] = {ACC_W{1'b0}};
        end
        for (int g = 0; g < PIPELINE_STAGE; g++) begin
            if (g == 0) begin
                a_in_s[g]   = a;
                b_in_s[g]   = b;
                acc_in_s[g] = {ACC_W{1'b0}};
            end else begin
                a_in_s[g]   = a_r[g-1];
                b_in_s[g]   = b_r[g-1];
                acc_in_s[g] = acc_r[g-1];
            end
            acc_next_s[g] = slice_sum(a_in_s[g], b_in_s[g], acc_in_s[g], g);
        end
    end

    // Pipeline registers. Reset clears every stage, which drops all products in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < PIPELINE_STAGE; g++) begin
                a_r[g]   <= {DATA_LEN{1'b0}};
                b_r[g]   <= {DATA_LEN{1'b0}};
                acc_r[g] <= {ACC_W{1'b0}};
            end
        end else begin
            for (int g = 0; g < PIPELINE_STAGE; g++) begin
                a_r[g]   <= a_in_s[g];
                b_r[g]   <= b_in_s[g];
                acc_r[g] <= acc_next_s[g];
            end
        end
    end

    assign result = acc_r[PIPELINE_STAGE-1][DATA_LEN-1:0];

`ifdef MULT_OVERFLOW_FLAG_EN
    assign overflow = |acc_r[PIPELINE_STAGE-1][ACC_W-1:DATA_LEN];
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
// ---------------------------------------------------------------------------
// tb_pipelined_multiplier
//
// Directed self-checking bench for pipelined_multiplier. The main instance
// uses DATA_LEN=32 and PIPELINE_STAGE=2. Three more instances use
// PIPELINE_STAGE=1, 4 and 32 and check the latency. Expected values are
// hand-computed constants, except in the random section, which compares
// against a native 64-bit product.
// ---------------------------------------------------------------------------
module tb_pipelined_multiplier;

    localparam int DL = 32;
    localparam logic [31:0] MAX32 = 32'hFFFF_FFFF;

    logic          clk;
    logic          reset;
    logic [DL-1:0] a;
    logic [DL-1:0] b;
    logic [DL-1:0] result;
    logic [DL-1:0] res_p1;
    logic [DL-1:0] res_p4;
    logic [DL-1:0] res_p32;
`ifdef MULT_OVERFLOW_FLAG_EN
    logic          overflow;
    logic          ovf_p1;
    logic          ovf_p4;
    logic          ovf_p32;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    pipelined_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(2)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
`ifdef MULT_OVERFLOW_FLAG_EN
        .overflow(overflow),
`endif
        .result(result));

    pipelined_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(1)) dut_p1 (
        .clk(clk), .reset(reset), .a(a), .b(b),
`ifdef MULT_OVERFLOW_FLAG_EN
        .overflow(ovf_p1),
`endif
        .result(res_p1));

    pipelined_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(4)) dut_p4 (
        .clk(clk), .reset(reset), .a(a), .b(b),
`ifdef MULT_OVERFLOW_FLAG_EN
        .overflow(ovf_p4),
`endif
        .result(res_p4));

    pipelined_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(32)) dut_p32 (
        .clk(clk), .reset(reset), .a(a), .b(b),
`ifdef MULT_OVERFLOW_FLAG_EN
        .overflow(ovf_p32),
`endif
        .result(res_p32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fail-safe in case the run somehow never reaches the summary.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge. Outputs are sampled and inputs changed 1ns after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one pair, then zeros; check the main instance two edges after capture.
    task automatic single_pair(input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp, input logic exp_ovf, input string tag);
        a = av; b = bv;
        tick;
        a = 32'd0; b = 32'd0;
        tick;
        check_val(tag, {32'd0, result}, {32'd0, exp});
`ifdef MULT_OVERFLOW_FLAG_EN
        check_val({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
`else
        if (exp_ovf) begin end else begin end
`endif
    endtask

    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [31:0] bb_exp [4];
    logic [63:0] exp_q  [$];
    logic [63:0] prod;
    logic        seen81;

    initial begin
        reset = 1'b1; a = 32'd0; b = 32'd0;
        #1;
        tick; tick;
        check_val("reset_result", {32'd0, result}, 64'd0);
        check_val("reset_result_p32", {32'd0, res_p32}, 64'd0);
`ifdef MULT_OVERFLOW_FLAG_EN
        check_val("reset_overflow", {63'd0, overflow}, 64'd0);
`endif
        reset = 1'b0;
        tick; tick;

        // Latency test: 12345*678 = 8369910 appears after exactly P edges, and the output is zero on every other cycle.
        a = 32'd12345; b = 32'd678;
        for (int n = 1; n <= 34; n++) begin
            tick;
            if (n == 1) begin
                a = 32'd0; b = 32'd0;
            end
            check_val($sformatf("lat_p2_n%0d", n),  {32'd0, result},  (n == 2)  ? 64'd8369910 : 64'd0);
            check_val($sformatf("lat_p1_n%0d", n),  {32'd0, res_p1},  (n == 1)  ? 64'd8369910 : 64'd0);
            check_val($sformatf("lat_p4_n%0d", n),  {32'd0, res_p4},  (n == 4)  ? 64'd8369910 : 64'd0);
            check_val($sformatf("lat_p32_n%0d", n), {32'd0, res_p32}, (n == 32) ? 64'd8369910 : 64'd0);
        end

        // 3*5: the output is still 0 after the capture edge, 15 after the next edge, and 0 after that.
        a = 32'd3; b = 32'd5;
        tick;
        check_val("p3x5_capture", {32'd0, result}, 64'd0);
        a = 32'd0; b = 32'd0;
        tick;
        check_val("p3x5_result", {32'd0, result}, 64'd15);
        tick;
        check_val("p3x5_after", {32'd0, result}, 64'd0);

        // Boundary cases
        single_pair(MAX32, 32'd2, 32'hFFFF_FFFE, 1'b1, "max_x2");
        single_pair(MAX32, MAX32, 32'h0000_0001, 1'b1, "max_x_max");
        single_pair(32'h1234_5678, 32'd1, 32'h1234_5678, 1'b0, "a_x1");
        single_pair(32'd0, 32'hCAFE_F00D, 32'd0, 1'b0, "zero_x_any");
        single_pair(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "pow2_wrap");
        single_pair(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, "no_wrap_full");

        // Back-to-back pairs on consecutive cycles. Results come out in order, one per cycle.
        bb_a[0] = 32'd7;  bb_b[0] = 32'd6;           bb_exp[0] = 32'd42;
        bb_a[1] = 32'd100; bb_b[1] = 32'd100;        bb_exp[1] = 32'd10000;
        bb_a[2] = 32'd0;  bb_b[2] = 32'd12345;       bb_exp[2] = 32'd0;
        bb_a[3] = 32'd1;  bb_b[3] = 32'hDEAD_BEEF;   bb_exp[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a = bb_a[i]; b = bb_b[i];
            end else begin
                a = 32'd0; b = 32'd0;
            end
            tick;
            if (i >= 1) check_val($sformatf("b2b_%0d", i - 1), {32'd0, result}, {32'd0, bb_exp[i-1]});
        end
        a = 32'd0; b = 32'd0;
        tick;
        check_val("b2b_drain", {32'd0, result}, 64'd0);

        // Reset in mid-flight: 9*9 is captured and then discarded, so 81 must never appear.
        seen81 = 1'b0;
        a = 32'd9; b = 32'd9;
        tick;
        reset = 1'b1; a = 32'd0; b = 32'd0;
        tick;
        check_val("midreset_result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (result == 32'd81) seen81 = 1'b1;
        end
        check_val("midreset_no81", {63'd0, seen81}, 64'd0);
        single_pair(32'd4, 32'd4, 32'd16, 1'b0, "post_reset_4x4");

        // Random pairs. The reference is a native 64-bit product, delayed by two cycles through a queue.
        exp_q.delete();
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                a = $urandom; b = $urandom;
            end else begin
                a = 32'd0; b = 32'd0;
            end
            prod = {32'd0, a} * {32'd0, b};
            exp_q.push_back(prod);
            tick;
            if (exp_q.size() == 2) begin
                prod = exp_q.pop_front();
                check_val("rand_result", {32'd0, result}, {32'd0, prod[31:0]});
`ifdef MULT_OVERFLOW_FLAG_EN
                check_val("rand_overflow", {63'd0, overflow}, {63'd0, |prod[63:32]});
`endif
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
